// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the multiply arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mult_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] result;
  logic        err;
  logic        busy;
  logic        m_start;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic        m_ready;
  logic [15:0] m_r;

  modport slave (
    input  req, req_a, req_b, m_ready, m_r,
    output gnt, done, result, err, busy, m_start, m_a, m_b
  );

  modport master (
    output req, req_a, req_b, m_ready, m_r,
    input  gnt, done, result, err, busy, m_start, m_a, m_b
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one add-shift multiplier among four requesters.
// All state advances on the falling clock edge; one job is in flight at a time.
module mult_arbiter #(
  parameter int TIMEOUT = 31
) (
  input logic           clock,
  input logic           reset,
  mult_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    last_winner;
  logic [1:0]    idx;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [CW-1:0] cnt;
  logic [3:0]    gnt_q;
  logic [3:0]    done_q;
  logic [15:0]   result_q;
  logic          err_q;
  logic          busy_q;
  logic          start_q;

  logic [1:0]    winner;
  logic [1:0]    cand;
  logic          found;

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  // Search begins one past the previous winner, so each requester waits for at most three others.
  always_comb begin
    winner = last_winner;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_winner + 2'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_winner <= 2'd3;
      idx         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      cnt         <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state       <= ISSUE;
            last_winner <= winner;
            idx         <= winner;
            op_a        <= bus.req_a[8*winner +: 8];
            op_b        <= bus.req_b[8*winner +: 8];
            gnt_q       <= onehot(winner);
            busy_q      <= 1'b1;
            start_q     <= 1'b1;
            cnt         <= '0;
          end
        end

        ISSUE: begin
          if (bus.m_ready) begin
            state   <= ACK;
            start_q <= 1'b0;
            cnt     <= '0;
          end
        end

        // A multiplier that never drops ready after the start strobe is treated as faulty.
        ACK: begin
          if (!bus.m_ready) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt != '0) begin
            state    <= DONE;
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= onehot(idx);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RUN: begin
          if (bus.m_ready) begin
            state    <= DONE;
            result_q <= bus.m_r;
            done_q   <= onehot(idx);
          end else if (cnt == CNT_LAST) begin
            state    <= DONE;
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= onehot(idx);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Returning to IDLE without arbitrating gives waiting requesters a fresh search next cycle.
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          op_a   <= '0;
          op_b   <= '0;
          cnt    <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.m_start = start_q;
  assign bus.m_a     = op_a;
  assign bus.m_b     = op_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, scoreboard of expected
// results, and a behavioural add-shift multiplier with fault injection modes.
module tb_mult_arbiter;

  localparam int TIMEOUT = 31;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mult_arbiter_if bus ();

  mult_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Multiplier model: mode 0 well-behaved, 1 ready stuck high, 2 never finishes.
  int          mul_mode = 0;
  int          run_len  = 3;
  logic        mul_rdy;
  logic [15:0] mul_r;
  logic [15:0] mul_prod;
  int          mul_cnt;

  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      mul_rdy  <= 1'b1;
      mul_cnt  <= 0;
      mul_r    <= '0;
      mul_prod <= '0;
    end else if (mul_rdy && bus.m_start) begin
      mul_rdy  <= 1'b0;
      mul_cnt  <= run_len;
      mul_prod <= 16'(bus.m_a) * 16'(bus.m_b);
    end else if (!mul_rdy && mul_mode != 2) begin
      if (mul_cnt <= 1) begin
        mul_rdy <= 1'b1;
        mul_r   <= mul_prod;
      end else begin
        mul_cnt <= mul_cnt - 1;
      end
    end
  end

  assign bus.m_ready = (mul_mode == 1) ? 1'b1 : mul_rdy;
  assign bus.m_r     = mul_r;

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        grant_log[$];

  logic [3:0]  req_snap;
  logic [31:0] a_snap;
  logic [31:0] b_snap;
  int          mode_snap;

  always @(negedge clock) begin
    req_snap  <= bus.req;
    a_snap    <= bus.req_a;
    b_snap    <= bus.req_b;
    mode_snap <= mul_mode;
  end

  int          cyc = 0;
  int          gnt_count = 0;
  int          done_count = 0;
  int          last_gnt_cyc = 0;
  int          last_done_cyc = 0;
  logic [3:0]  last_gnt = '0;
  logic [3:0]  last_done = '0;
  logic [15:0] last_result = '0;
  logic        last_err = 1'b0;
  int          rr_last = 3;
  int          w;
  sb_entry_t   e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      int c = (last + i) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Grants push expectations built from the operands seen at the grant edge; dones pop them.
  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      sb.delete();
      rr_last = 3;
    end else begin
      if (bus.gnt != 4'b0) begin
        w = rr_pick(rr_last, req_snap);
        if (w < 0) begin
          check("grant_spurious", 32'(bus.gnt), 32'h0);
        end else begin
          check("grant_rr", 32'(bus.gnt), 32'(4'b0001 << w));
          rr_last = w;
          e.idx = w;
          e.err = (mode_snap != 0);
          e.res = e.err ? 16'h0000 : 16'(a_snap[8*w +: 8]) * 16'(b_snap[8*w +: 8]);
          sb.push_back(e);
          grant_log.push_back(w);
        end
        gnt_count++;
        last_gnt     = bus.gnt;
        last_gnt_cyc = cyc;
      end
      if (bus.done != 4'b0) begin
        done_count++;
        last_done     = bus.done;
        last_result   = bus.result;
        last_err      = bus.err;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          check("done_unexpected", 32'(bus.done), 32'h0);
        end else begin
          e = sb.pop_front();
          check("sb_done", 32'(bus.done), 32'(4'b0001 << e.idx));
          check("sb_result", 32'(bus.result), 32'(e.res));
          check("sb_err", 32'(bus.err), 32'(e.err));
        end
      end else if (bus.err) begin
        check("err_without_done", 32'h1, 32'h0);
      end
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    int          run_len;
    int          mode;
    logic [3:0]  exp_gnt;
    logic [15:0] exp_result;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_gnt(input int start, input int n, input string name);
    int k = 0;
    while (gnt_count < start + n && k < 400) begin
      @(posedge clock);
      #1;
      k++;
    end
    check(name, 32'(gnt_count - start), 32'(n));
  endtask

  task automatic wait_done(input int start, input int n, input string name);
    int k = 0;
    while (done_count < start + n && k < 400) begin
      @(posedge clock);
      #1;
      k++;
    end
    check(name, 32'(done_count - start), 32'(n));
  endtask

  task automatic settle();
    int k = 0;
    mul_mode = 0;
    while ((bus.busy || !bus.m_ready) && k < 200) begin
      step();
      k++;
    end
    step();
  endtask

  task automatic do_reset();
    @(posedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic apply_stimulus(input vec_t v, input int n);
    int g0 = gnt_count;
    run_len   = v.run_len;
    mul_mode  = v.mode;
    bus.req_a = v.a;
    bus.req_b = v.b;
    bus.req   = v.req;
    wait_gnt(g0, 1, $sformatf("vec%0d_gnt_seen", n));
    check($sformatf("vec%0d_gnt", n), 32'(last_gnt), 32'(v.exp_gnt));
    step();
    bus.req = '0;
  endtask

  task automatic check_output(input vec_t v, input int n, input int d0);
    wait_done(d0, 1, $sformatf("vec%0d_done_seen", n));
    check($sformatf("vec%0d_done", n), 32'(last_done), 32'(v.exp_gnt));
    check($sformatf("vec%0d_result", n), 32'(last_result), 32'(v.exp_result));
    check($sformatf("vec%0d_err", n), 32'(last_err), 32'(v.exp_err));
    if (v.exp_lat > 0)
      check($sformatf("vec%0d_latency", n), 32'(last_done_cyc - last_gnt_cyc), 32'(v.exp_lat));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g0;
    int d0;
    int exp_a[5];
    int exp_b[4];

    vecs[0] = '{4'b0001, 32'h0000_0003, 32'h0000_0005, 3, 0, 4'b0001, 16'h000F, 1'b0, 0};
    vecs[1] = '{4'b0100, 32'h00FF_0000, 32'h00FF_0000, 5, 0, 4'b0100, 16'hFE01, 1'b0, 0};
    vecs[2] = '{4'b1000, 32'h0011_2233, 32'hC844_5566, 1, 0, 4'b1000, 16'h0000, 1'b0, 0};
    vecs[3] = '{4'b0010, 32'h7766_0C55, 32'h9988_0D44, 8, 0, 4'b0010, 16'h009C, 1'b0, 0};
    vecs[4] = '{4'b0001, 32'h0000_00FF, 32'h0000_0001, 1, 0, 4'b0001, 16'h00FF, 1'b0, 0};
    vecs[5] = '{4'b0010, 32'h0000_0700, 32'h0000_0900, 3, 1, 4'b0010, 16'h0000, 1'b1, 3};
    vecs[6] = '{4'b0100, 32'h0004_0000, 32'h0004_0000, 3, 2, 4'b0100, 16'h0000, 1'b1, TIMEOUT + 2};

    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    #1 reset = 1'b0;
    #2;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_m_start", 32'(bus.m_start), 32'h0);
    check("rst_m_ab", 32'({bus.m_a, bus.m_b}), 32'h0);
    check("rst_result", 32'(bus.result), 32'h0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    reset = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      d0 = done_count;
      apply_stimulus(vecs[i], i);
      check_output(vecs[i], i, d0);
      settle();
    end

    // All four requesting at once: strict rotation starting after requester 3.
    do_reset();
    grant_log.delete();
    run_len   = 2;
    bus.req_a = {8'd5, 8'd4, 8'd3, 8'd2};
    bus.req_b = {8'd13, 8'd12, 8'd11, 8'd10};
    g0 = gnt_count;
    d0 = done_count;
    bus.req = 4'b1111;
    wait_gnt(g0, 5, "all4_grants");
    step();
    bus.req = '0;
    wait_done(d0, 5, "all4_dones");
    exp_a = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++)
      check($sformatf("all4_order%0d", i), 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(exp_a[i]));
    settle();

    // Two persistent requesters alternate; max operands exercise the full product width.
    do_reset();
    grant_log.delete();
    run_len   = 4;
    bus.req_a = 32'h00FF_00FF;
    bus.req_b = 32'h00FF_00FF;
    g0 = gnt_count;
    d0 = done_count;
    bus.req = 4'b0101;
    wait_gnt(g0, 4, "alt_grants");
    step();
    bus.req = '0;
    wait_done(d0, 4, "alt_dones");
    exp_b = '{0, 2, 0, 2};
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_order%0d", i), 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(exp_b[i]));
    check("alt_result", 32'(last_result), 32'h0000_FE01);
    settle();

    // A request raised and withdrawn while busy never earns a grant.
    run_len   = 6;
    bus.req_a = 32'h0000_0006;
    bus.req_b = 32'h0000_0007;
    g0 = gnt_count;
    d0 = done_count;
    bus.req = 4'b0001;
    wait_gnt(g0, 1, "drop_first_gnt");
    step();
    bus.req = 4'b1000;
    step();
    step();
    bus.req = '0;
    wait_done(d0, 1, "drop_first_done");
    check("drop_result", 32'(last_result), 32'h0000_002A);
    repeat (15) step();
    check("drop_no_grant", 32'(gnt_count - g0), 32'h1);
    settle();

    // Reset while the multiplier is running discards the job silently.
    run_len   = 20;
    bus.req_a = 32'h0000_0A00;
    bus.req_b = 32'h0000_0B00;
    g0 = gnt_count;
    bus.req = 4'b0010;
    wait_gnt(g0, 1, "rstrun_gnt");
    step();
    bus.req = '0;
    repeat (3) step();
    d0 = done_count;
    @(posedge clock);
    reset = 1'b0;
    #1;
    check("rstrun_busy", 32'(bus.busy), 32'h0);
    check("rstrun_m_start", 32'(bus.m_start), 32'h0);
    check("rstrun_m_ab", 32'({bus.m_a, bus.m_b}), 32'h0);
    check("rstrun_outs", 32'({bus.gnt, bus.done, bus.err}), 32'h0);
    check("rstrun_result", 32'(bus.result), 32'h0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    reset = 1'b1;
    repeat (30) step();
    check("rstrun_no_done", 32'(done_count - d0), 32'h0);
    run_len = 3;
    g0 = gnt_count;
    d0 = done_count;
    bus.req = 4'b0010;
    wait_gnt(g0, 1, "rstrun_regnt_seen");
    check("rstrun_regnt", 32'(last_gnt), 32'h2);
    step();
    bus.req = '0;
    wait_done(d0, 1, "rstrun_redone");
    check("rstrun_reresult", 32'(last_result), 32'h0000_006E);
    settle();

    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
